// File: rtl/demux_pkg.sv
// Shared definitions for the demux14 scheduler slice.
//   NUM_CH        : number of consumer channels
//   SEL_W         : width of a channel index
//   sched_state_e : scheduler FSM state (IDLE = buffer empty, HOLD = buffer full)
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;
endpackage

// File: rtl/demux_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requesting channel, searching start, start+1, ... mod NUM_CH.
//   req   in  NUM_CH : request vector (one bit per channel)
//   start in  SEL_W  : first channel to examine
//   idx   out SEL_W  : chosen channel (equals start when nothing requests)
//   found out 1      : at least one channel requested
module demux_rr_pick
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  start,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);
    logic [SEL_W-1:0] cand;

    // Walk the search order backwards so the earliest hit is the last write.
    always_comb begin
        idx   = start;
        found = 1'b0;
        cand  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = start + SEL_W'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux14_sched.sv
// Round-robin scheduler front end for a 1:4 demux.
// Accepts one word via In_valid/In_ready, holds it, and steers it to the
// first ready channel (searched from the round-robin pointer) using Sel and
// a one-hot Out_valid. The target is frozen until that channel takes it.
// Optional macro DEMUX_SCHED_CNT_EN adds per-channel delivery counters and
// the Cnt port.
//   clk, rst  : clock, asynchronous active-high reset
//   In_data/In_valid/In_ready : input handshake
//   Out_ready : per-channel consumer ready
//   Out_data/Out_valid/Sel    : held word, one-hot target valid, target index
//   Busy      : a word is held
//   Cnt       : delivered-word counts, channel 0 in LSBs (macro only)
module demux14_sched
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] In_data,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [NUM_CH-1:0] Out_ready,
    output logic [DATA_W-1:0] Out_data,
    output logic [NUM_CH-1:0] Out_valid,
    output logic [SEL_W-1:0]  Sel,
    output logic              Busy
`ifdef DEMUX_SCHED_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] Cnt
`endif
);
    sched_state_e      state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0] out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              complete;
    logic              accept;
    logic [SEL_W-1:0]  search_start;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic [SEL_W-1:0]  target;

    // Only the held target's ready matters; other channels are ignored in HOLD.
    assign complete = (state_q == HOLD) && Out_ready[sel_q];
    assign In_ready = (state_q == IDLE) || complete;
    assign accept   = In_valid && In_ready;

    // On a same-cycle complete+accept the pointer register is stale, so the
    // search starts from the channel after the one just served.
    assign search_start = complete ? sel_q + SEL_W'(1) : ptr_q;

    demux_rr_pick u_pick (
        .req   (Out_ready),
        .start (search_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign target = pick_found ? pick_idx : search_start;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        if (complete) begin
            ptr_d       = sel_q + SEL_W'(1);
            state_d     = IDLE;
            out_valid_d = '0;
            busy_d      = 1'b0;
        end
        if (accept) begin
            data_d      = In_data;
            sel_d       = target;
            state_d     = HOLD;
            out_valid_d = {{(NUM_CH-1){1'b0}}, 1'b1} << target;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            data_q      <= '0;
            out_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign Out_data  = data_q;
    assign Out_valid = out_valid_q;
    assign Sel       = sel_q;
    assign Busy      = busy_q;

`ifdef DEMUX_SCHED_CNT_EN
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (complete && (sel_q == SEL_W'(gi))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign Cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
`else
    // Counter width has no effect without the counter feature.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif
endmodule
